sram_req_adapter: RTL and testbench

//  Initiator for the SyncRam port: converts a valid/ready request stream (read or byte-masked write)

---
 rtl/sram_req_adapter.sv | 88 ++++++++
 tb/tb_sram_req_adapter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_req_adapter.sv
// sram_req_adapter: valid/ready request stream to a SyncRam port, in-order responses through a 2-entry buffer.
// Optional address range check enabled by defining SRAM_REQ_ADAPTER_ERR_EN.
module sram_req_adapter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 1 << (ADDR_WIDTH - $clog2(DATA_WIDTH / 8))
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [DATA_WIDTH-1:0]   req_wdata,
    input  logic [DATA_WIDTH/8-1:0] req_wstrb,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic                    resp_write,
    output logic [DATA_WIDTH-1:0]   resp_rdata,
    output logic                    resp_err,
    output logic [ADDR_WIDTH-1:0]   ram_raddr,
    output logic [ADDR_WIDTH-1:0]   ram_waddr,
    output logic [DATA_WIDTH/8-1:0] ram_wstrb,
    output logic [DATA_WIDTH-1:0]   ram_wdata,
    input  logic [DATA_WIDTH-1:0]   ram_rdata
);
    localparam int OFF = $clog2(DATA_WIDTH / 8);
    localparam int RW  = DATA_WIDTH + 2;

    if (DEPTH < 1 || DATA_WIDTH % 8 != 0) begin : g_bad_cfg
        $error("sram_req_adapter: bad DEPTH or DATA_WIDTH");
    end

    logic            fire, err, push, pop, nonempty;
    logic            s1_valid, s1_write, s1_err;
    logic            wptr, rptr;
    logic [1:0]      count;
    logic [DATA_WIDTH-1:0] s1_rdata;
    logic [RW-1:0]   s1_word, head;
    logic [RW-1:0]   mem [2];

`ifdef SRAM_REQ_ADAPTER_ERR_EN
    localparam logic [ADDR_WIDTH:0] LIMIT = (ADDR_WIDTH + 1)'(DEPTH);
    assign err = {1'b0, req_addr >> OFF} >= LIMIT;
`else
    assign err = 1'b0;
`endif

    // Occupancy of s1 plus FIFO never exceeds 2, so the buffer cannot overflow.
    assign req_ready = !reset && (count + {1'b0, s1_valid} <= 2'd1);

    always_comb begin
        fire       = req_valid && req_ready;
        nonempty   = count != 2'd0;
        push       = s1_valid && !(!nonempty && resp_ready);
        pop        = nonempty && resp_ready;
        s1_rdata   = (s1_write || s1_err) ? '0 : ram_rdata;
        s1_word    = {s1_write, s1_err, s1_rdata};
        head       = nonempty ? mem[rptr] : s1_word;
        resp_valid = nonempty || s1_valid;
        {resp_write, resp_err, resp_rdata} = head;
        ram_raddr  = req_addr;
        ram_waddr  = req_addr;
        ram_wdata  = req_wdata;
        ram_wstrb  = (fire && req_write && !err) ? req_wstrb : '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_write <= 1'b0;
            s1_err   <= 1'b0;
            wptr     <= 1'b0;
            rptr     <= 1'b0;
            count    <= 2'd0;
        end else begin
            s1_valid <= fire;
            s1_write <= fire && req_write;
            s1_err   <= fire && err;
            if (push) wptr <= ~wptr;
            if (pop) rptr <= ~rptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    always_ff @(posedge clock)
        if (push) mem[wptr] <= s1_word;
endmodule

// File: tb/tb_sram_req_adapter.sv
// tb_sram_req_adapter: scoreboard bench with a behavioural SyncRam and a reference word model.
module tb_sram_req_adapter;
    localparam int AW = 12;
    localparam int DW = 32;
    localparam int SW = DW / 8;
    localparam int WORDS = 1 << (AW - 2);
`ifdef SRAM_REQ_ADAPTER_ERR_EN
    localparam int DEPTH = 512;
    localparam bit ERR_EN = 1'b1;
`else
    localparam int DEPTH = WORDS;
    localparam bit ERR_EN = 1'b0;
`endif

    typedef struct {
        logic          w;
        logic          e;
        logic [DW-1:0] d;
        int            cyc;
    } exp_t;

    logic clock = 1'b0, reset = 1'b1;
    logic req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic [SW-1:0] req_wstrb = '0;
    logic resp_valid, resp_ready = 1'b1, resp_write, resp_err;
    logic [DW-1:0] resp_rdata;
    logic [AW-1:0] ram_raddr, ram_waddr;
    logic [SW-1:0] ram_wstrb;
    logic [DW-1:0] ram_wdata, ram_rdata;

    logic [DW-1:0] ram [WORDS] = '{default: '0};
    logic [DW-1:0] ref_mem [WORDS] = '{default: '0};
    exp_t q[$];
    exp_t got;
    int checks = 0, errors = 0, cyc = 0, resp_n = 0;
    bit lat_chk = 1'b0;

    sram_req_adapter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_write(resp_write),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .ram_raddr(ram_raddr), .ram_waddr(ram_waddr), .ram_wstrb(ram_wstrb),
        .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    // Behavioural SyncRam: 1-cycle read latency, read-before-write.
    always @(posedge clock) begin
        ram_rdata <= ram[ram_raddr[AW-1:2]];
        for (int b = 0; b < SW; b++)
            if (ram_wstrb[b]) ram[ram_waddr[AW-1:2]][b*8 +: 8] <= ram_wdata[b*8 +: 8];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void record();
        exp_t e;
        int idx;
        logic er;
        idx = int'(req_addr >> 2);
        er = ERR_EN && idx >= DEPTH;
        e.w = req_write;
        e.e = er;
        e.cyc = cyc;
        e.d = (req_write || er) ? '0 : ref_mem[idx];
        if (req_write && !er)
            for (int b = 0; b < SW; b++)
                if (req_wstrb[b]) ref_mem[idx][b*8 +: 8] = req_wdata[b*8 +: 8];
        q.push_back(e);
    endfunction

    always @(negedge clock)
        if (!reset && resp_valid && resp_ready) begin
            if (q.size() == 0) chk("resp_unexpected", 64'd1, 64'd0);
            else begin
                got = q.pop_front();
                chk("resp_write", 64'(resp_write), 64'(got.w));
                chk("resp_err", 64'(resp_err), 64'(got.e));
                chk("resp_rdata", 64'(resp_rdata), 64'(got.d));
                if (lat_chk) chk("resp_latency", 64'(cyc - got.cyc), 64'd1);
                resp_n++;
            end
        end

    task automatic issue(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input logic [SW-1:0] s);
        int t;
        bit fired;
        t = 0;
        fired = 1'b0;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_wstrb = s;
        while (!fired && t < 200) begin
            @(negedge clock);
            if (req_ready) begin
                fired = 1'b1;
                record();
            end
            @(posedge clock); #1;
            t++;
        end
        if (!fired) chk("req_timeout", 64'd0, 64'd1);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (q.size() != 0 && t < 50) begin
            @(posedge clock); #1;
            t++;
        end
        chk("drain_empty", 64'(q.size()), 64'd0);
    endtask

    initial begin
        int base;
        // Reset held with a request pending
        req_valid = 1'b1; resp_ready = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_ram_wstrb", 64'(ram_wstrb), 64'd0);
        req_valid = 1'b0; reset = 1'b0;
        #1;
        chk("rel_req_ready", 64'(req_ready), 64'd1);
        @(posedge clock); #1;

        // Full write then read, latency 1
        lat_chk = 1'b1;
        issue(1'b1, 12'h100, 32'hDEADBEEF, 4'hF);
        issue(1'b0, 12'h100, '0, '0);
        // Partial write
        issue(1'b1, 12'h102, 32'h11223344, 4'h3);
        issue(1'b0, 12'h101, '0, '0);
        drain();
        chk("data_dead3344", 64'(ref_mem[12'h100 >> 2]), 64'hDEAD3344);

        // Back-to-back reads while the consumer stalls
        issue(1'b1, 12'h104, 32'h55667788, 4'hF);
        issue(1'b1, 12'h108, 32'h99AABBCC, 4'hF);
        issue(1'b1, 12'h10C, 32'h0BADF00D, 4'hF);
        drain();
        lat_chk = 1'b0;
        base = resp_n;
        resp_ready = 1'b0;
        issue(1'b0, 12'h100, '0, '0);
        issue(1'b0, 12'h104, '0, '0);
        chk("stall_req_ready", 64'(req_ready), 64'd0);
        repeat (3) @(posedge clock);
        #1;
        chk("stall_req_ready_held", 64'(req_ready), 64'd0);
        chk("stall_resp_valid", 64'(resp_valid), 64'd1);
        chk("stall_no_resp", 64'(resp_n - base), 64'd0);
        resp_ready = 1'b1;
        issue(1'b0, 12'h108, '0, '0);
        issue(1'b0, 12'h10C, '0, '0);
        drain();
        chk("stall_resp_count", 64'(resp_n - base), 64'd4);

        // Reset in the middle of buffered responses
        resp_ready = 1'b0;
        issue(1'b0, 12'h100, '0, '0);
        issue(1'b0, 12'h104, '0, '0);
        reset = 1'b1;
        #1;
        chk("midrst_resp_valid", 64'(resp_valid), 64'd0);
        chk("midrst_req_ready", 64'(req_ready), 64'd0);
        q.delete();
        @(posedge clock); #1;
        reset = 1'b0; resp_ready = 1'b1;
        #1;
        chk("midrst_resp_valid_after", 64'(resp_valid), 64'd0);
        chk("midrst_req_ready_after", 64'(req_ready), 64'd1);

`ifdef SRAM_REQ_ADAPTER_ERR_EN
        // Out-of-range write is answered with an error and leaves the RAM alone
        issue(1'b1, 12'h900, 32'hCAFEF00D, 4'hF);
        issue(1'b0, 12'h900, '0, '0);
        issue(1'b0, 12'h000, '0, '0);
        drain();
        chk("err_ram_unchanged", 64'(ram[12'h900 >> 2]), 64'd0);
`endif

        // Random traffic against the reference model
        for (int i = 0; i < 10000; i++) begin
            req_valid = 1'($urandom_range(0, 1));
            req_write = 1'($urandom_range(0, 1));
            req_addr = AW'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
            req_wdata = $urandom;
            req_wstrb = SW'($urandom);
            resp_ready = $urandom_range(0, 3) != 0;
            @(negedge clock);
            if (req_valid && req_ready) record();
            @(posedge clock); #1;
        end
        req_valid = 1'b0; resp_ready = 1'b1;
        drain();
        for (int i = 0; i < 16; i++) chk("final_ram", 64'(ram[i]), 64'(ref_mem[i]));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
